// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: opcode width and bitwise opcode encodings shared by the logic unit
package logic_unit_pkg;
  localparam int OPW = 3;
  localparam logic [OPW-1:0] OP_AND   = 3'b000;
  localparam logic [OPW-1:0] OP_OR    = 3'b001;
  localparam logic [OPW-1:0] OP_XOR   = 3'b010;
  localparam logic [OPW-1:0] OP_NOTA  = 3'b011;
  localparam logic [OPW-1:0] OP_NAND  = 3'b100;
  localparam logic [OPW-1:0] OP_NOR   = 3'b101;
  localparam logic [OPW-1:0] OP_XNOR  = 3'b110;
  localparam logic [OPW-1:0] OP_PASSB = 3'b111;
endpackage

// File: rtl/logic_unit_core.sv
// logic_unit_core: combinational bitwise op with zero and odd-parity flags
module logic_unit_core import logic_unit_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   sel,
  output logic [WIDTH-1:0] f,
  output logic             zero,
  output logic             parity
);
  always_comb begin
    f = sel == OP_AND  ? x & b :
        sel == OP_OR   ? x | b :
        sel == OP_XOR  ? x ^ b :
        sel == OP_NOTA ? ~x :
        sel == OP_NAND ? ~(x & b) :
        sel == OP_NOR  ? ~(x | b) :
        sel == OP_XNOR ? ~(x ^ b) : b;
    zero = ~|f;
    parity = ^f;
  end
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready bitwise logic unit with result accumulator
module logic_unit_pipe import logic_unit_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int OPW   = logic_unit_pkg::OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OPW-1:0]   Sel,
  input  logic             Acc_en,
  input  logic             acc_clr,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] F,
  output logic             Zero,
  output logic             Parity,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, f_q, f_d, acc_q, acc_d, x, core_f;
  logic [OPW-1:0] sel_q, sel_d;
  logic acc_en_q, acc_en_d, s1_valid_q, s1_valid_d, zero_q, zero_d, parity_q, parity_d;
  logic out_valid_q, out_valid_d, core_zero, core_parity;
  logic s2_adv, s1_adv, in_xfer, s2_load;
  assign x = acc_en_q ? acc_q : a_q;
  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .x(x), .b(b_q), .sel(sel_q), .f(core_f), .zero(core_zero), .parity(core_parity)
  );
  always_comb begin
    s2_adv = !out_valid_q | out_ready;
    s1_adv = !s1_valid_q | s2_adv;
    in_ready = s1_adv & rst_n;
    in_xfer = in_valid & in_ready;
    s2_load = s2_adv & s1_valid_q;
    a_d = in_xfer ? A : a_q;
    b_d = in_xfer ? B : b_q;
    sel_d = in_xfer ? Sel : sel_q;
    acc_en_d = in_xfer ? Acc_en : acc_en_q;
    s1_valid_d = s1_adv ? in_xfer : s1_valid_q;
    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
    f_d = s2_load ? core_f : f_q;
    zero_d = s2_load ? core_zero : zero_q;
    parity_d = s2_load ? core_parity : parity_q;
    acc_d = acc_clr ? '0 : s2_load ? core_f : acc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      sel_q <= '0;
      acc_en_q <= 1'b0;
      s1_valid_q <= 1'b0;
      f_q <= '0;
      zero_q <= 1'b0;
      parity_q <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      sel_q <= sel_d;
      acc_en_q <= acc_en_d;
      s1_valid_q <= s1_valid_d;
      f_q <= f_d;
      zero_q <= zero_d;
      parity_q <= parity_d;
      out_valid_q <= out_valid_d;
      acc_q <= acc_d;
    end
  end
  assign F = f_q;
  assign Zero = zero_q;
  assign Parity = parity_q;
  assign out_valid = out_valid_q;
endmodule
